// File: rtl/ght_upd_queue_pkg.sv
// Shared types for the GHT update queue: entry record, drain FSM states and
// the 2-bit saturating counter helpers.
package ght_upd_queue_pkg;

   localparam int GHT_AW = 13;

   typedef struct packed {
      logic [GHT_AW-1:0] addr;
      logic              taken;
      logic              thread;
      logic              live;
   } ght_upd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WB
   } ght_state_e;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'd3) ? c : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'd0) ? c : c - 2'd1;
   endfunction

endpackage

// File: rtl/ght_upd_queue_fifo.sv
// Circular update store with push/pop, occupancy count and a per-thread
// live-bit clear; flushed entries stay in place until popped.
module ght_upd_fifo
   import ght_upd_queue_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  ght_upd_t               push_data,
   input  logic                   pop,
   input  logic                   flush,
   input  logic                   flush_thread,
   output ght_upd_t               head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   ght_upd_t      mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign do_pop = pop && (count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (flush && mem[i].thread == flush_thread) mem[i].live <= 1'b0;
         // the slot being written is free, so the push simply overrides
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // a flush landing this cycle already kills the head for the drain logic
   always_comb begin
      head = mem[rd_ptr];
      if (flush && head.thread == flush_thread) head.live = 1'b0;
   end

endmodule

// File: rtl/ght_upd_queue.sv
// GHT update queue: records each update in the in-flight CAM and drains the
// queue as read-modify-write operations on 2-bit saturating counters.
module ght_upd_queue
   import ght_upd_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = GHT_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   input  logic          in_taken,
   input  logic          in_thread,
   output logic          in_ready,
   output logic [AW-1:0] cam_write_addr,
   output logic          cam_write_wen,
   output logic          cam_write_thread,
   output logic          tbl_rd_en,
   output logic [AW-1:0] tbl_rd_addr,
   input  logic [1:0]    tbl_rd_data,
   output logic          tbl_wr_en,
   output logic [AW-1:0] tbl_wr_addr,
   output logic [1:0]    tbl_wr_data,
   input  logic          tbl_busy,
   input  logic          except,
   input  logic          except_thread,
   output logic          empty
);

   localparam int CW = $clog2(DEPTH) + 1;

   ght_state_e    state, state_nxt;
   ght_upd_t      head, work, push_data;
   logic [CW-1:0] count;
   logic          accept, pop, issue, has_head, hazard, flush_work, wr_go;
   logic          wr_en_q;

   assign accept     = in_valid && in_ready;
   assign in_ready   = (count != CW'(DEPTH)) && !(except && except_thread == in_thread);
   assign has_head   = (count != '0);
   assign flush_work = except && (except_thread == work.thread);
   assign wr_go      = work.live && !flush_work;
   // hold a same-address read back one cycle so it sees the counter being written
   assign hazard     = (state == ST_WB) && (head.addr == work.addr);
   assign push_data  = '{addr: in_addr, taken: in_taken, thread: in_thread, live: 1'b1};

   ght_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push         (accept),
      .push_data    (push_data),
      .pop          (pop),
      .flush        (except),
      .flush_thread (except_thread),
      .head         (head),
      .count        (count)
   );

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      issue     = 1'b0;
      case (state)
         ST_IDLE, ST_WB: begin
            if (state == ST_WB) state_nxt = ST_IDLE;
            if (has_head && !head.live) begin
               pop = 1'b1;
            end else if (has_head && !tbl_busy && !hazard) begin
               pop       = 1'b1;
               issue     = 1'b1;
               state_nxt = ST_RD;
            end
         end
         ST_RD:   state_nxt = wr_go ? ST_WB : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         work             <= '0;
         wr_en_q          <= 1'b0;
         tbl_wr_addr      <= '0;
         tbl_wr_data      <= '0;
         cam_write_wen    <= 1'b0;
         cam_write_addr   <= '0;
         cam_write_thread <= 1'b0;
      end else begin
         state         <= state_nxt;
         cam_write_wen <= accept;
         if (accept) begin
            cam_write_addr   <= in_addr;
            cam_write_thread <= in_thread;
         end
         if (issue)           work      <= head;
         else if (flush_work) work.live <= 1'b0;
         wr_en_q <= (state == ST_RD) && wr_go;
         if (state == ST_RD && wr_go) begin
            tbl_wr_addr <= work.addr;
            tbl_wr_data <= work.taken ? sat_inc(tbl_rd_data) : sat_dec(tbl_rd_data);
         end
      end
   end

   // reset kills table traffic in the very cycle it is asserted
   assign tbl_rd_en   = issue && !rst;
   assign tbl_rd_addr = tbl_rd_en ? head.addr : '0;
   assign tbl_wr_en   = wr_en_q && !rst;
   assign empty       = !has_head && (state == ST_IDLE);

endmodule

// File: tb/tb_ght_upd_queue.sv
// Bench for ght_upd_queue: a counter RAM model answers the table port, a
// vector table and corner sequences check timing, and a random run is
// scored against in-order application of every accepted update.
module tb_ght_upd_queue;
   import ght_upd_queue_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_taken, in_thread, in_ready;
   logic [AW-1:0] in_addr;
   logic [AW-1:0] cam_write_addr;
   logic          cam_write_wen, cam_write_thread;
   logic          tbl_rd_en, tbl_wr_en, tbl_busy, except, except_thread, empty;
   logic [AW-1:0] tbl_rd_addr, tbl_wr_addr;
   logic [1:0]    tbl_rd_data, tbl_wr_data;

   always #5 clk = ~clk;

   ght_upd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_addr(in_addr), .in_taken(in_taken),
      .in_thread(in_thread), .in_ready(in_ready),
      .cam_write_addr(cam_write_addr), .cam_write_wen(cam_write_wen),
      .cam_write_thread(cam_write_thread),
      .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
      .tbl_busy(tbl_busy), .except(except), .except_thread(except_thread),
      .empty(empty)
   );

   // counter RAM: read data one cycle after the request
   logic [1:0]    ram [0:(1<<AW)-1];
   logic [1:0]    rd_q = 2'd0;
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [1:0]    pl_data;
   int            cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tbl_rd_en) rd_q <= ram[tbl_rd_addr];
      if (tbl_wr_en) ram[tbl_wr_addr] <= tbl_wr_data;
      if (pl_en)     ram[pl_addr] <= pl_data;
   end
   assign tbl_rd_data = rd_q;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [1:0]    data;
      logic          thr;
   } ev_t;

   ev_t rd_log[$], wr_log[$], cam_log[$];

   always @(negedge clk) begin
      if (tbl_rd_en)     rd_log.push_back('{cyc, tbl_rd_addr, 2'd0, 1'b0});
      if (tbl_wr_en)     wr_log.push_back('{cyc, tbl_wr_addr, tbl_wr_data, 1'b0});
      if (cam_write_wen) cam_log.push_back('{cyc, cam_write_addr, 2'd0, cam_write_thread});
   end

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int next_ctr(input int c, input logic t);
      if (t) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick(1);
      pl_en = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic t, input logic th, output int acc);
      in_valid = 1'b1; in_addr = a; in_taken = t; in_thread = th;
      acc = cyc;
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      tbl_busy = 1'b0;
      while (!empty && n < 200) begin
         tick(1);
         n++;
      end
      chk(name, empty, 1);
      tick(1);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; tbl_busy = 1'b0; except = 1'b0; except_thread = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_cam_wen"}, cam_write_wen, 0);
      chk({tag, "_cam_addr"}, cam_write_addr, 0);
      chk({tag, "_cam_thr"}, cam_write_thread, 0);
      chk({tag, "_rd_en"}, tbl_rd_en, 0);
      chk({tag, "_rd_addr"}, tbl_rd_addr, 0);
      chk({tag, "_wr_en"}, tbl_wr_en, 0);
      chk({tag, "_wr_addr"}, tbl_wr_addr, 0);
      chk({tag, "_wr_data"}, tbl_wr_data, 0);
      chk({tag, "_empty"}, empty, 1);
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic          taken;
      logic          thr;
      logic [1:0]    init;
      logic [1:0]    exp;
   } vec_t;

   initial begin
      vec_t vt[7];
      int   acc, b_rd, b_wr, b_cam;
      logic [1:0] mtbl [8];
      ev_t  exp_q[$], cam_q[$], e;

      vt[0] = '{13'h0A5,  1'b1, 1'b0, 2'd2, 2'd3};
      vt[1] = '{13'h0A6,  1'b1, 1'b1, 2'd3, 2'd3};
      vt[2] = '{13'h0A7,  1'b0, 1'b0, 2'd0, 2'd0};
      vt[3] = '{13'h1FFF, 1'b0, 1'b1, 2'd2, 2'd1};
      vt[4] = '{13'h000,  1'b1, 1'b0, 2'd0, 2'd1};
      vt[5] = '{13'h123,  1'b0, 1'b1, 2'd1, 2'd0};
      vt[6] = '{13'h0B0,  1'b1, 1'b0, 2'd1, 2'd2};

      rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_taken = 1'b0; in_thread = 1'b0;
      tbl_busy = 1'b0; except = 1'b0; except_thread = 1'b0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      tick(3);
      rst = 1'b0;
      check_reset("rst");

      // single updates: CAM on accept+1, read on accept+1, write on accept+3
      for (int i = 0; i < 7; i++) begin
         preload(vt[i].addr, vt[i].init);
         b_rd = rd_log.size(); b_wr = wr_log.size(); b_cam = cam_log.size();
         push(vt[i].addr, vt[i].taken, vt[i].thr, acc);
         drain("vec_empty");
         chk("vec_cam_n", cam_log.size() - b_cam, 1);
         chk("vec_rd_n", rd_log.size() - b_rd, 1);
         chk("vec_wr_n", wr_log.size() - b_wr, 1);
         if (cam_log.size() > b_cam) begin
            chk("vec_cam_addr", cam_log[b_cam].addr, vt[i].addr);
            chk("vec_cam_thr", cam_log[b_cam].thr, vt[i].thr);
            chk("vec_cam_lat", cam_log[b_cam].cyc - acc, 1);
         end
         if (rd_log.size() > b_rd) begin
            chk("vec_rd_addr", rd_log[b_rd].addr, vt[i].addr);
            chk("vec_rd_lat", rd_log[b_rd].cyc - acc, 1);
         end
         if (wr_log.size() > b_wr) begin
            chk("vec_wr_addr", wr_log[b_wr].addr, vt[i].addr);
            chk("vec_wr_data", wr_log[b_wr].data, vt[i].exp);
            chk("vec_wr_lat", wr_log[b_wr].cyc - acc, 3);
         end
      end

      // fill to full under tbl_busy, then drain in order at one RMW per 2 cycles
      for (int i = 0; i < 16; i++) preload(AW'(13'h200 + i), 2'(i % 4));
      tbl_busy = 1'b1;
      b_rd = rd_log.size(); b_wr = wr_log.size(); b_cam = cam_log.size();
      for (int i = 0; i < 16; i++) begin
         chk("full_rdy_pre", in_ready, 1);
         push(AW'(13'h200 + i), (i % 2 == 1), 1'b0, acc);
      end
      chk("full_rdy_full", in_ready, 0);
      tick(1);
      chk("full_cam_n", cam_log.size() - b_cam, 16);
      chk("full_no_rd_busy", rd_log.size() - b_rd, 0);
      tbl_busy = 1'b0;
      tick(1);
      chk("full_rdy_after_pop", in_ready, 1);
      drain("full_empty");
      chk("full_wr_n", wr_log.size() - b_wr, 16);
      for (int i = 0; i < 16; i++) begin
         if (wr_log.size() > b_wr + i) begin
            chk("full_wr_addr", wr_log[b_wr+i].addr, 13'h200 + i);
            chk("full_wr_data", wr_log[b_wr+i].data, next_ctr(i % 4, (i % 2 == 1)));
            if (i > 0) chk("full_wr_gap", wr_log[b_wr+i].cyc - wr_log[b_wr+i-1].cyc, 2);
         end
      end

      // per-thread flush: only thread-0 entries write
      do_reset();
      for (int i = 0; i < 8; i++) preload(AW'(13'h300 + i), 2'd1);
      tbl_busy = 1'b1;
      b_wr = wr_log.size(); b_cam = cam_log.size();
      for (int i = 0; i < 8; i++) push(AW'(13'h300 + i), 1'b1, (i % 2 == 1), acc);
      except = 1'b1; except_thread = 1'b1; in_addr = 13'h3FF; in_thread = 1'b0;
      #1;
      chk("flush_rdy_thr0", in_ready, 1);
      in_thread = 1'b1; in_valid = 1'b1;
      #1;
      chk("flush_rdy_thr1", in_ready, 0);
      tick(1);
      except = 1'b0; in_valid = 1'b0;
      tick(1);
      chk("flush_cam_n", cam_log.size() - b_cam, 8);
      drain("flush_empty");
      chk("flush_wr_n", wr_log.size() - b_wr, 4);
      for (int i = 0; i < 4; i++)
         if (wr_log.size() > b_wr + i) begin
            chk("flush_wr_addr", wr_log[b_wr+i].addr, 13'h300 + 2 * i);
            chk("flush_wr_data", wr_log[b_wr+i].data, 2);
         end

      // flush of the working entry while in RD suppresses its write
      do_reset();
      preload(13'h400, 2'd1);
      preload(13'h401, 2'd1);
      b_rd = rd_log.size(); b_wr = wr_log.size();
      push(13'h400, 1'b1, 1'b1, acc);
      push(13'h401, 1'b1, 1'b0, acc);
      except = 1'b1; except_thread = 1'b1;
      tick(1);
      except = 1'b0;
      drain("rdflush_empty");
      chk("rdflush_rd_n", rd_log.size() - b_rd, 2);
      chk("rdflush_wr_n", wr_log.size() - b_wr, 1);
      if (wr_log.size() > b_wr) begin
         chk("rdflush_wr_addr", wr_log[b_wr].addr, 13'h401);
         chk("rdflush_wr_data", wr_log[b_wr].data, 2);
      end
      chk("rdflush_ram_kept", ram[13'h400], 1);

      // same-address back-to-back: second read waits for the first write
      preload(13'h100, 2'd1);
      b_rd = rd_log.size(); b_wr = wr_log.size();
      push(13'h100, 1'b1, 1'b0, acc);
      push(13'h100, 1'b1, 1'b0, acc);
      drain("haz_empty");
      chk("haz_wr_n", wr_log.size() - b_wr, 2);
      chk("haz_rd_n", rd_log.size() - b_rd, 2);
      if (wr_log.size() > b_wr + 1 && rd_log.size() > b_rd + 1) begin
         chk("haz_wr0_data", wr_log[b_wr].data, 2);
         chk("haz_wr1_data", wr_log[b_wr+1].data, 3);
         chk("haz_rd1_after_wr0", rd_log[b_rd+1].cyc - wr_log[b_wr].cyc, 1);
         chk("haz_wr_gap", wr_log[b_wr+1].cyc - wr_log[b_wr].cyc, 3);
      end
      chk("haz_ram_final", ram[13'h100], 3);

      // reset during WB: the pending write never reaches the table
      preload(13'h500, 2'd2);
      b_wr = wr_log.size();
      push(13'h500, 1'b1, 1'b0, acc);
      tick(2);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check_reset("midrst");
      tick(3);
      chk("midrst_wr_n", wr_log.size() - b_wr, 0);
      chk("midrst_ram_kept", ram[13'h500], 2);

      // random traffic against in-order application of accepted updates
      do_reset();
      for (int a = 0; a < 8; a++) begin
         mtbl[a] = 2'($urandom_range(0, 3));
         preload(AW'(a), mtbl[a]);
      end
      for (int c = 0; c < 700; c++) begin
         if (c < 400) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_addr   = AW'($urandom_range(0, 7));
            in_taken  = 1'($urandom_range(0, 1));
            in_thread = 1'($urandom_range(0, 1));
            tbl_busy  = ($urandom_range(0, 9) < 3);
         end else begin
            in_valid = 1'b0;
            tbl_busy = 1'b0;
         end
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back('{cyc, in_addr, {1'b0, in_taken}, in_thread});
            cam_q.push_back('{cyc, in_addr, 2'd0, in_thread});
         end
         @(negedge clk);
         if (cam_write_wen) begin
            if (cam_q.size() == 0) chk("rand_cam_unexpected", 1, 0);
            else begin
               e = cam_q.pop_front();
               chk("rand_cam_addr", cam_write_addr, e.addr);
               chk("rand_cam_thr", cam_write_thread, e.thr);
            end
         end
         if (tbl_wr_en) begin
            if (exp_q.size() == 0) chk("rand_wr_unexpected", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("rand_wr_addr", tbl_wr_addr, e.addr);
               mtbl[e.addr[2:0]] = 2'(next_ctr(mtbl[e.addr[2:0]], e.data[0]));
               chk("rand_wr_data", tbl_wr_data, mtbl[e.addr[2:0]]);
            end
         end
         @(posedge clk);
         #1;
         if (c >= 400 && empty && exp_q.size() == 0) break;
      end
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_cam_drained", cam_q.size(), 0);
      for (int a = 0; a < 8; a++) chk("rand_ram_final", ram[AW'(a)], mtbl[a]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
